// File: rtl/rtc_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the rtcclock register slave.
// Grants are held for the whole bus cycle; a watchdog terminates unacknowledged strobes.
module rtc_wb_arbiter #(
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } state_t;

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic                m0_req, m1_req;
    logic                tmo;
    logic                gnt_cyc, gnt_stb;

    assign m0_req    = m0_cyc_i & m0_stb_i;
    assign m1_req    = m1_cyc_i & m1_stb_i;
    assign tmo       = (state_q != IDLE) && (wcnt_q == WCNT_W'(TIMEOUT));
    assign timeout_o = tmo;

    // Datapath steering: the granted master sees the slave, the other sees zeros.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        gnt_o    = 2'b00;
        gnt_cyc  = 1'b0;
        gnt_stb  = 1'b0;
        case (state_q)
            GNT0: begin
                gnt_o    = 2'b01;
                gnt_cyc  = m0_cyc_i;
                gnt_stb  = m0_stb_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~tmo;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i | tmo;
                m0_dat_o = tmo ? TIMEOUT_DATA : s_dat_i;
            end
            GNT1: begin
                gnt_o    = 2'b10;
                gnt_cyc  = m1_cyc_i;
                gnt_stb  = m1_stb_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~tmo;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i | tmo;
                m1_dat_o = tmo ? TIMEOUT_DATA : s_dat_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                if (m0_req && m1_req) state_d = ptr_q ? GNT1 : GNT0;
                else if (m0_req)      state_d = GNT0;
                else if (m1_req)      state_d = GNT1;
            end
            GNT0, GNT1: begin
                // Release hands priority to the other master.
                if (!gnt_cyc) begin
                    state_d = IDLE;
                    ptr_d   = (state_q == GNT0);
                    wcnt_d  = '0;
                end else if (s_ack_i || tmo) begin
                    wcnt_d = '0;
                end else if (gnt_stb) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wcnt_q  <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_rtc_wb_arbiter.sv
// Directed self-checking bench for rtc_wb_arbiter, built with a short watchdog (TIMEOUT = 4).
module tb_rtc_wb_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic        m0_ack_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_ack_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    rtc_wb_arbiter #(.TIMEOUT(4), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Advance past the next rising edge; inputs are then driven and outputs checked mid-cycle.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'hF; m0_adr_i = '0; m0_dat_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'hF; m1_adr_i = '0; m1_dat_i = '0;
        s_ack_i = 0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        wb_rst_i = 1;
        tick();
        tick();
        wb_rst_i = 0;
        settle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt_o); end
        checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b expected 0", s_cyc_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
        s_ack_i = 1; s_dat_i = 32'hAAAA_5555;
        settle();
        checks++; if ({m0_ack_o, m1_ack_o} !== 2'b00) begin errors++; $display("FAIL idle_ack_ignored: got %b expected 00", {m0_ack_o, m1_ack_o}); end
        checks++; if (m0_dat_o !== 32'h0) begin errors++; $display("FAIL idle_dat: got %h expected 00000000", m0_dat_o); end
        s_ack_i = 0; s_dat_i = '0;
    endtask

    task automatic test_single_read();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h3000_0004;
        settle();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL single_req_cycle_gnt: got %b expected 00", gnt_o); end
        tick();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b expected 01", gnt_o); end
        checks++; if ({s_cyc_o, s_stb_o} !== 2'b11) begin errors++; $display("FAIL single_s_cyc_stb: got %b expected 11", {s_cyc_o, s_stb_o}); end
        checks++; if (s_adr_o !== 32'h3000_0004) begin errors++; $display("FAIL single_s_adr: got %h expected 30000004", s_adr_o); end
        checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL single_early_ack: got %b expected 0", m0_ack_o); end
        tick();
        checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL single_wait_ack: got %b expected 0", m0_ack_o); end
        tick();
        s_ack_i = 1; s_dat_i = 32'h0000_1234;
        settle();
        checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL single_ack: got %b expected 1", m0_ack_o); end
        checks++; if (m0_dat_o !== 32'h0000_1234) begin errors++; $display("FAIL single_dat: got %h expected 00001234", m0_dat_o); end
        checks++; if (m1_ack_o !== 1'b0) begin errors++; $display("FAIL single_m1_ack: got %b expected 0", m1_ack_o); end
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        settle();
        checks++; if ({s_cyc_o, gnt_o} !== 3'b001) begin errors++; $display("FAIL single_release: got %b expected 001", {s_cyc_o, gnt_o}); end
        tick();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL single_idle: got %b expected 00", gnt_o); end
    endtask

    task automatic test_round_robin();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0010;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_0020;
        tick();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rr_first_gnt: got %b expected 01", gnt_o); end
        s_ack_i = 1; s_dat_i = 32'h0000_00A0;
        settle();
        checks++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin errors++; $display("FAIL rr_ack_route: got %b expected 10", {m0_ack_o, m1_ack_o}); end
        checks++; if (m1_dat_o !== 32'h0) begin errors++; $display("FAIL rr_m1_dat_zero: got %h expected 00000000", m1_dat_o); end
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL rr_gap: got %b expected 00", gnt_o); end
        tick();
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL rr_second_gnt: got %b expected 10", gnt_o); end
        checks++; if (s_adr_o !== 32'h0000_0020) begin errors++; $display("FAIL rr_m1_adr: got %h expected 00000020", s_adr_o); end
        s_ack_i = 1;
        tick();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rr_third_gnt: got %b expected 01", gnt_o); end
        idle_inputs();
        tick();
    endtask

    task automatic test_locked_cycle();
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'h3; m1_adr_i = 32'h3000_0008;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int unsigned i = 0; i < 3; i++) begin
            m1_stb_i = 1; m1_dat_i = 32'h0000_0100 + i; s_ack_i = 1;
            settle();
            checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL locked_gnt_%0d: got %b expected 10", i, gnt_o); end
            checks++; if ({m1_ack_o, m0_ack_o} !== 2'b10) begin errors++; $display("FAIL locked_ack_%0d: got %b expected 10", i, {m1_ack_o, m0_ack_o}); end
            checks++; if (s_dat_o !== 32'h0000_0100 + i) begin errors++; $display("FAIL locked_wdat_%0d: got %h expected %h", i, s_dat_o, 32'h0000_0100 + i); end
            tick();
            m1_stb_i = 0; s_ack_i = 0;
            tick();
        end
        checks++; if ({s_we_o, s_sel_o} !== 5'b1_0011) begin errors++; $display("FAIL locked_we_sel: got %b expected 10011", {s_we_o, s_sel_o}); end
        m1_cyc_i = 0; m1_we_i = 0;
        tick();
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL locked_release: got %b expected 00", gnt_o); end
        tick();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL locked_m0_after: got %b expected 01", gnt_o); end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int unsigned c = 1; c <= 6; c++) begin
            tick();
            if (c == 5) begin
                checks++; if ({m0_ack_o, timeout_o, s_stb_o} !== 3'b110) begin errors++; $display("FAIL tmo_cycle5: got ack/tmo/stb %b expected 110", {m0_ack_o, timeout_o, s_stb_o}); end
                checks++; if (m0_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tmo_data: got %h expected deadbeef", m0_dat_o); end
            end else begin
                checks++; if ({m0_ack_o, timeout_o, s_stb_o} !== 3'b001) begin errors++; $display("FAIL tmo_wait_%0d: got ack/tmo/stb %b expected 001", c, {m0_ack_o, timeout_o, s_stb_o}); end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_ack_on_timeout();
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1;
        for (int unsigned c = 1; c <= 10; c++) begin
            tick();
            s_ack_i = (c == 5); s_dat_i = 32'h5555_5555;
            settle();
            if (c == 5) begin
                checks++; if ({m1_ack_o, timeout_o} !== 2'b11) begin errors++; $display("FAIL coinc_ack: got ack/tmo %b expected 11", {m1_ack_o, timeout_o}); end
                checks++; if (m1_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL coinc_data: got %h expected deadbeef", m1_dat_o); end
            end else if (c == 10) begin
                checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL coinc_restart_tmo: got %b expected 1", timeout_o); end
            end else if (c > 5) begin
                checks++; if ({m1_ack_o, timeout_o} !== 2'b00) begin errors++; $display("FAIL coinc_after_%0d: got ack/tmo %b expected 00", c, {m1_ack_o, timeout_o}); end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL rst_mid_gnt: got %b expected 10", gnt_o); end
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; wb_rst_i = 1;
        settle();
        checks++; if (m1_ack_o !== 1'b0) begin errors++; $display("FAIL rst_mid_pre_ack: got %b expected 0", m1_ack_o); end
        tick();
        wb_rst_i = 0;
        settle();
        checks++; if ({gnt_o, s_cyc_o, m1_ack_o} !== 4'b0000) begin errors++; $display("FAIL rst_mid_after: got gnt/cyc/ack %b expected 0000", {gnt_o, s_cyc_o, m1_ack_o}); end
        tick();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rst_mid_next_gnt: got %b expected 01", gnt_o); end
        idle_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no completion expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        idle_inputs();
        wb_rst_i = 1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_locked_cycle();
        test_timeout();
        test_ack_on_timeout();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_wb_arbiter.md
# rtc_wb_arbiter

Two-master Wishbone arbiter sharing the single `rtcclock` register slave inside `user_project_wrapper`. Master 0 is the management SoC Wishbone port. Master 1 is a logic-analyzer-driven bridge used for bring-up. The arbiter grants in round-robin order and holds each grant for the whole bus cycle. A watchdog terminates any transfer the slave fails to acknowledge, so a hung RTC can never lock up the management SoC bus.

## Interface
Parameters:
- TIMEOUT, 255: cycles a granted strobe may wait for `s_ack_i` before the arbiter terminates it (1..1023).
- TIMEOUT_DATA, 32'hDEAD_BEEF: read data returned on a timed-out transfer.

Ports:
- wb_clk_i  input  1  sole clock; all state changes on its rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  master 0 cycle, strobe, write enable.
- m0_sel_i  input  4  master 0 byte selects.
- m0_adr_i, m0_dat_i  input  32 each  master 0 address, write data.
- m0_ack_o  output  1  master 0 acknowledge.
- m0_dat_o  output  32  master 0 read data.
- m1_*  same set and widths as m0_*, for master 1.
- s_cyc_o, s_stb_o, s_we_o  output  1 each  to `rtcclock`.
- s_sel_o  output  4  to `rtcclock`.
- s_adr_o, s_dat_o  output  32 each  to `rtcclock`.
- s_ack_i  input  1  from `rtcclock`.
- s_dat_i  input  32  from `rtcclock`.
- gnt_o  output  2  one-hot current grant; 2'b00 when idle.
- timeout_o  output  1  one-cycle pulse on each watchdog termination.

## Operation
- Request: `mN_req = mN_cyc_i & mN_stb_i`.
- States: IDLE, GNT0, GNT1. Grant state and priority pointer `ptr` are registered; `ptr` resets to 0.
- IDLE:
  - Only one master requesting: grant it.
  - Both requesting: grant master `ptr`.
  - Neither requesting: stay in IDLE.
- GNTn:
  - Slave outputs = master n inputs. `s_cyc_o = mn_cyc_i`, `s_stb_o = mn_stb_i & ~tmo`.
  - `mn_ack_o = s_ack_i | tmo`.
  - `mn_dat_o = tmo ? TIMEOUT_DATA : s_dat_i`.
  - Non-granted master: ack 0, dat 0.
- GNTn exits to IDLE when `mn_cyc_i` is sampled low; `ptr` is set to the other master on that edge. The grant is held across back-to-back strobes while cyc stays high, which is required for RMW sequences.
- Outside GNTn, all `s_*` outputs are 0.
- Watchdog counter `wcnt` (width clog2(TIMEOUT+1)):
  - Cleared on grant entry and on any cycle with `s_ack_i` or `tmo`.
  - Otherwise increments while the granted master's stb is high.
  - `tmo = (wcnt == TIMEOUT)`.
  - `timeout_o = tmo`.
- `s_ack_i` arriving while no grant is held: ignored.
- `s_ack_i` arriving on the `tmo` cycle: only a single ack is issued, carrying TIMEOUT_DATA.
- Reset (including mid-transfer): on the next edge, state = IDLE, `ptr` = 0, `wcnt` = 0. All outputs are then 0 (`gnt_o` = 0, all acks 0, `s_cyc_o` = 0). An in-flight transfer is dropped with no ack.

## Timing
- Arbitration latency is 1 cycle: request sampled in IDLE at edge k → `gnt_o` and `s_cyc_o`/`s_stb_o` high after edge k.
- Data path is combinational in the granted state: slave ack at cycle j → master ack at cycle j, with zero added latency.
- Release: master drops cyc at cycle j → `s_cyc_o` low at cycle j (combinational). State is IDLE after edge j. The earliest new grant is after edge j+1.
- Timeout: granted stb high and slave silent → `tmo` asserts in the (TIMEOUT+1)th cycle of the wait, for exactly 1 cycle, and `s_stb_o` is low in that cycle.
- Throughput: one transfer per cycle is possible within a held grant (`wcnt` clears on each ack).

## Test plan
- Single master: m0 read at adr 0x3000_0004 with slave ack 2 cycles after stb, s_dat_i 0x0000_1234 → `gnt_o` = 01 one cycle after request; m0_ack_o coincides with s_ack_i; m0_dat_o = 0x1234; m1_ack_o stays 0.
- Simultaneous requests after reset:
  - m0 granted first.
  - After m0 drops cyc, m1 granted 2 cycles later.
  - Next simultaneous request after that grants m0.
- Locked cycle: m1 issues 3 writes with cyc held high while m0 requests continuously → `gnt_o` stays 10 through all 3 acks; m0 is granted only after m1 cyc falls.
- Timeout: TIMEOUT = 4, slave never acks → m0_ack_o pulses in the 5th cycle of stb with m0_dat_o = 0xDEAD_BEEF; timeout_o pulses once; s_stb_o is low that cycle.
- Coincident ack and timeout: s_ack_i arrives on the tmo cycle → exactly one ack, TIMEOUT_DATA returned, wcnt = 0 afterwards.
- Reset mid-transfer: assert wb_rst_i while GNT1 is waiting on the slave → after the edge, gnt_o = 00, s_cyc_o = 0, no ack to m1; the next simultaneous request grants m0.
